// File: rtl/glitch_pkg.sv
// Shared types and helpers for the glitch sequencer.
// Holds the FSM state enum, default widths and a saturating adder.
package glitch_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Unsigned add clamped to max; callers cast back to their width.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// Two-flop synchronizer plus rising-edge detect for a button input.
// Ports: i_clk, i_rst (sync, active-high), i_async (raw), o_rise (1-cycle).
module glitch_trig_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/glitch_sequencer.sv
// Cycle-accurate scheduler for the VCC and reset glitch outputs.
// One trigger runs: reset hold, delay, then N drop pulses with gaps.
// Inputs : i_clk, i_clk_reset (sync, active-high), i_vcc_en, i_trigger,
//          i_abort, i_rst_hold, i_delay, i_width, i_gap, i_num,
//          i_sweep_step, i_sweep_clr.
// Outputs: o_glitch, o_glitch_reset, o_busy, o_done, o_pulse_cnt,
//          o_cur_delay (all registered).
// Option : define GLITCH_SWEEP_EN to add a per-sequence delay sweep.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_clk_reset,
    input  logic             i_vcc_en,
    input  logic             i_trigger,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_rst_hold,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_gap,
    input  logic [NUM_W-1:0] i_num,
    input  logic [CNT_W-1:0] i_sweep_step,
    input  logic             i_sweep_clr,
    output logic             o_glitch,
    output logic             o_glitch_reset,
    output logic             o_busy,
    output logic             o_done,
    output logic [NUM_W-1:0] o_pulse_cnt,
    output logic [CNT_W-1:0] o_cur_delay
);

    localparam logic [CNT_W-1:0] L_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] L_ONE_N = {{(NUM_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_MAX   = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NUM_W-1:0] w_pcnt_nxt;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [NUM_W-1:0] r_num;
    logic [CNT_W-1:0] w_eff_delay;
    logic [CNT_W-1:0] w_width_in;
    logic [CNT_W-1:0] w_gap_in;
    logic [NUM_W-1:0] w_num_in;
    logic             w_rise;
    logic             w_accept;

    glitch_trig_sync u_trig (
        .i_clk   (i_clk),
        .i_rst   (i_clk_reset),
        .i_async (i_trigger),
        .o_rise  (w_rise)
    );

`ifdef GLITCH_SWEEP_EN
    logic [CNT_W-1:0] r_offset;

    assign w_eff_delay = CNT_W'(sat_add(32'(i_delay), 32'(r_offset),
                                        32'(L_MAX)));

    // Clear beats the end-of-sequence increment.
    always_ff @(posedge i_clk) begin
        if (i_clk_reset) begin
            r_offset <= '0;
        end else if (i_sweep_clr) begin
            r_offset <= '0;
        end else if (r_state == DONE) begin
            r_offset <= CNT_W'(sat_add(32'(r_offset), 32'(i_sweep_step),
                                       32'(L_MAX)));
        end
    end
`else
    logic w_unused_sweep;

    assign w_eff_delay    = i_delay;
    assign w_unused_sweep = ^{i_sweep_step, i_sweep_clr};
`endif

    assign w_width_in = (i_width == '0) ? L_ONE_C : i_width;
    assign w_gap_in   = (i_gap == '0) ? L_ONE_C : i_gap;
    assign w_num_in   = (i_num == '0) ? L_ONE_N : i_num;
    assign w_accept   = (r_state == IDLE) && w_rise && i_vcc_en;

    // Each phase loads length-1 and leaves when the counter hits 0.
    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_pcnt_nxt = o_pulse_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_pcnt_nxt = '0;
                    if (i_rst_hold != '0) begin
                        w_next    = HOLD;
                        w_cnt_nxt = i_rst_hold - L_ONE_C;
                    end else if (w_eff_delay != '0) begin
                        w_next    = DELAY;
                        w_cnt_nxt = w_eff_delay - L_ONE_C;
                    end else begin
                        w_next    = PULSE;
                        w_cnt_nxt = w_width_in - L_ONE_C;
                    end
                end
            end
            HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - L_ONE_C;
                end else if (r_delay != '0) begin
                    w_next    = DELAY;
                    w_cnt_nxt = r_delay - L_ONE_C;
                end else begin
                    w_next    = PULSE;
                    w_cnt_nxt = r_width - L_ONE_C;
                end
            end
            DELAY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - L_ONE_C;
                end else begin
                    w_next    = PULSE;
                    w_cnt_nxt = r_width - L_ONE_C;
                end
            end
            PULSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - L_ONE_C;
                end else begin
                    w_pcnt_nxt = o_pulse_cnt + L_ONE_N;
                    if (w_pcnt_nxt == r_num) begin
                        w_next = DONE;
                    end else begin
                        w_next    = GAP;
                        w_cnt_nxt = r_gap - L_ONE_C;
                    end
                end
            end
            GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - L_ONE_C;
                end else begin
                    w_next    = PULSE;
                    w_cnt_nxt = r_width - L_ONE_C;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Abort overrides the phase logic and freezes the pulse count.
        if ((r_state != IDLE) && i_abort) begin
            w_next     = IDLE;
            w_cnt_nxt  = r_cnt;
            w_pcnt_nxt = o_pulse_cnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_delay        <= '0;
            r_width        <= '0;
            r_gap          <= '0;
            r_num          <= '0;
            o_glitch       <= 1'b0;
            o_glitch_reset <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_pulse_cnt    <= '0;
            o_cur_delay    <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            o_pulse_cnt <= w_pcnt_nxt;
            if (w_accept) begin
                r_delay <= w_eff_delay;
                r_width <= w_width_in;
                r_gap   <= w_gap_in;
                r_num   <= w_num_in;
            end
            // Outputs are decoded from the next state so they line up
            // with the state register itself.
            o_glitch       <= i_vcc_en && (w_next != PULSE);
            o_glitch_reset <= (w_next == HOLD);
            o_busy         <= (w_next != IDLE);
            o_done         <= (w_next == DONE);
            if (r_state == IDLE) begin
                o_cur_delay <= w_eff_delay;
            end
        end
    end

endmodule
